gyro_rx_packetizer: RTL

GYRO_RX_PACKETIZER -- requirements
Module: gyro_rx_packetizer

---
 rtl/gyro_pkt_pkg.sv | 32 +++
 rtl/gyro_pkt_skid.sv | 64 ++++++
 rtl/gyro_rx_packetizer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gyro_pkt_pkg.sv
// Shared definitions for the gyro rx packetizer: FSM state encoding,
// header magic and field offsets, and the header beat builder.
package gyro_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2,
    S_PAD    = 2'd3
  } state_e;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_W         = 48;
  localparam int         HDR_MAGIC_LSB = 40;
  localparam int         HDR_CH_LSB    = 37;
  localparam int         HDR_SEL_LSB   = 34;
  localparam int         HDR_SEQ_LSB   = 18;
  localparam int         CNT_W         = 14;

  function automatic logic [HDR_W-1:0] make_header(input logic [2:0]  ch,
                                                   input logic [2:0]  sel,
                                                   input logic [15:0] seq);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_CH_LSB +: 3]    = ch;
    h[HDR_SEL_LSB +: 3]   = sel;
    h[HDR_SEQ_LSB +: 16]  = seq;
    return h;
  endfunction

endpackage

// File: rtl/gyro_pkt_skid.sv
// Two-entry skid buffer with registered outputs; in_ready depends only on
// local state so the upstream never sees a combinational path from out_ready.
module gyro_pkt_skid #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_fire;

  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      // Output register is free this cycle: drain the skid entry first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/gyro_rx_packetizer.sv
// Frames the rx sample stream into fixed-length packets (header + len beats)
// for the DMA, padding with zeros when enable drops mid-packet.
module gyro_rx_packetizer
  import gyro_pkt_pkg::*;
#(
  parameter int WD    = 48,
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             debug_clear,
  input  logic [2:0]       packet_sel,
  input  logic [2:0]       in_channel,
  input  logic [WD-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WD-1:0]    m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [SEQ_W-1:0] pkt_seq,
  output logic [15:0]      drop_count,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_HEADER = S_HEADER;
  localparam logic [1:0] ST_DATA   = S_DATA;
  localparam logic [1:0] ST_PAD    = S_PAD;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ch_q, ch_d;
  logic [SEQ_W-1:0] pkt_seq_q, pkt_seq_d;
  logic [SEQ_W-1:0] hdr_seq_q, hdr_seq_d;
  logic [15:0]      drop_q, drop_d;

  logic             sk_in_valid, sk_in_ready;
  logic [WD:0]      sk_in_data, sk_out_data;
  logic             s_ready_int;
  logic             drop_inc;
  logic [CNT_W-1:0] last_idx;
  logic             at_last;
  logic [WD-1:0]    hdr_beat;

  assign last_idx = (14'd64 << sel_q) - 14'd1;
  assign at_last  = (cnt_q == last_idx);
  // Header carries the sequence number of the packet it opens, which is
  // ahead of pkt_seq while the previous tlast still sits in the skid buffer.
  assign hdr_beat = WD'(make_header(ch_q, sel_q, 16'(hdr_seq_q)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ch_d        = ch_q;
    hdr_seq_d   = hdr_seq_q;
    sk_in_valid = 1'b0;
    sk_in_data  = '0;
    s_ready_int = 1'b0;
    drop_inc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_ready_int = 1'b1;
        drop_inc    = s_valid;
        if (enable) begin
          state_d = ST_HEADER;
          sel_d   = packet_sel;
          ch_d    = in_channel;
        end
      end
      ST_HEADER: begin
        sk_in_valid = 1'b1;
        sk_in_data  = {1'b0, hdr_beat};
        if (sk_in_ready) begin
          state_d   = enable ? ST_DATA : ST_PAD;
          hdr_seq_d = hdr_seq_q + SEQ_W'(1);
        end
      end
      ST_DATA: begin
        sk_in_valid = s_valid;
        sk_in_data  = {at_last, s_data};
        s_ready_int = sk_in_ready;
        if (s_valid && sk_in_ready) begin
          if (at_last) begin
            cnt_d = '0;
            if (enable) begin
              state_d = ST_HEADER;
              sel_d   = packet_sel;
              ch_d    = in_channel;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 14'd1;
            if (!enable) state_d = ST_PAD;
          end
        end else if (!enable) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        sk_in_valid = 1'b1;
        sk_in_data  = {at_last, {WD{1'b0}}};
        if (sk_in_ready) begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 14'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_seq_d = pkt_seq_q;
    if (m_tvalid && m_tready && m_tlast) pkt_seq_d = pkt_seq_q + SEQ_W'(1);
    drop_d = drop_q;
    if (debug_clear) drop_d = '0;
    else if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      ch_q      <= '0;
      pkt_seq_q <= '0;
      hdr_seq_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      ch_q      <= ch_d;
      pkt_seq_q <= pkt_seq_d;
      hdr_seq_q <= hdr_seq_d;
      drop_q    <= drop_d;
    end
  end

  gyro_pkt_skid #(.W(WD + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sk_in_valid),
    .in_data   (sk_in_data),
    .in_ready  (sk_in_ready),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (sk_out_data)
  );

  assign m_tdata     = sk_out_data[WD-1:0];
  assign m_tlast     = sk_out_data[WD];
  assign s_ready     = s_ready_int && !rst;
  assign pkt_seq     = pkt_seq_q;
  assign drop_count  = drop_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
